// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control requests and status outputs of the fetch program counter
interface pc_unit_if #(
    parameter int AW = 32
);
    logic          en_f;
    logic          ct_taken;
    logic [AW-1:0] ct_pc;
    logic          ras_push;
    logic [AW-1:0] ras_link;
    logic          ras_pop;
    logic          hlt;
    logic          start;
    logic [AW-1:0] pc;
    logic          halted;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_err;

    modport master (
        output en_f, ct_taken, ct_pc, ras_push, ras_link, ras_pop, hlt, start,
        input  pc, halted, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  en_f, ct_taken, ct_pc, ras_push, ras_link, ras_pop, hlt, start,
        output pc, halted, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with halt/resume; return-address stack built under PC_RAS_EN
module pc_unit #(
    parameter int            AW        = 32,
    parameter int            STEP      = 4,
    parameter logic [AW-1:0] RESET_PC  = '0,
    parameter int            RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    pc_unit_if.slave   bus
);
    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [AW-1:0] STEP_V = AW'(STEP);
    localparam logic [AW-1:0] ALIGN  = ~(STEP_V - AW'(1));

    state_t        state;
    logic          halted_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] target;
    logic          frozen;
    logic          redirect;

    // While halted (or entering halt) the PC is pinned and no redirect may touch the RAS.
    assign frozen   = bus.hlt || (state == S_HALT);
    assign redirect = bus.ct_taken && !frozen;

`ifdef PC_RAS_EN
    localparam int            PW       = $clog2(RAS_DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(RAS_DEPTH);

    logic [AW-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0] top;
    logic [PW:0]   count;
    logic          err_q;
    logic          has_top;

    assign has_top = (count != '0);
    assign target  = ((bus.ras_pop && has_top) ? ras_mem[top] : bus.ct_pc) & ALIGN;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            top   <= '0;
            count <= '0;
            err_q <= 1'b0;
        end else if (bus.hlt) begin
            count <= '0;
        end else if (redirect) begin
            if (bus.ras_push && bus.ras_pop && has_top) begin
                ras_mem[top] <= bus.ras_link;
            end else if (bus.ras_push) begin
                // Overflow overwrites the oldest entry; a pop on empty is an underflow.
                ras_mem[top + PW'(1)] <= bus.ras_link;
                top <= top + PW'(1);
                if (count != FULL_CNT)
                    count <= count + (PW+1)'(1);
                if ((count == FULL_CNT) || bus.ras_pop)
                    err_q <= 1'b1;
            end else if (bus.ras_pop) begin
                if (has_top) begin
                    top   <= top - PW'(1);
                    count <= count - (PW+1)'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ras_empty = (count == '0);
    assign bus.ras_full  = (count == FULL_CNT);
    assign bus.ras_err   = err_q;
`else
    localparam int unused_depth = RAS_DEPTH;
    logic unused_ras;

    assign unused_ras    = ^{bus.ras_push, bus.ras_pop, bus.ras_link};
    assign target        = bus.ct_pc & ALIGN;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= S_RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
        end else begin
            if (frozen)
                pc_q <= RESET_PC;
            else if (bus.ct_taken)
                pc_q <= target;
            else if (bus.en_f)
                pc_q <= pc_q + STEP_V;

            if (bus.hlt) begin
                state    <= S_HALT;
                halted_q <= 1'b1;
            end else if ((state == S_HALT) && bus.start) begin
                state    <= S_RUN;
                halted_q <= 1'b0;
            end
        end
    end

    assign bus.pc     = pc_q;
    assign bus.halted = halted_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed and random checks of pc_unit against a queue-based reference model
module tb_pc_unit;
    localparam int          DEPTH  = 4;
    localparam int          STEP   = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    pc_unit_if #(.AW(32)) b ();
    pc_unit_if #(.AW(8))  s ();

    pc_unit #(.AW(32), .STEP(STEP), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .n_rst(n_rst), .bus(b.slave)
    );
    pc_unit #(.AW(8), .STEP(STEP), .RESET_PC(8'h0), .RAS_DEPTH(DEPTH)) dut8 (
        .clk(clk), .n_rst(n_rst), .bus(s.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_err;
    logic [31:0] ras[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: RAS as a queue whose back is the top; PC from the priority rules.
    task automatic model_edge();
        logic [31:0] tgt;
        if (!n_rst) begin
            m_pc = RST_PC; m_halt = 0; m_err = 0; ras.delete();
            return;
        end
        if (b.hlt) begin
            m_pc = RST_PC; m_halt = 1; ras.delete();
        end else if (m_halt) begin
            m_pc = RST_PC;
            if (b.start) m_halt = 0;
        end else if (b.ct_taken) begin
            tgt = b.ct_pc;
`ifdef PC_RAS_EN
            if (b.ras_pop && ras.size() > 0) tgt = ras[ras.size()-1];
            if (b.ras_push && b.ras_pop && ras.size() > 0) begin
                ras[ras.size()-1] = b.ras_link;
            end else begin
                if (b.ras_pop) begin
                    if (ras.size() > 0) void'(ras.pop_back());
                    else m_err = 1;
                end
                if (b.ras_push) begin
                    if (ras.size() == DEPTH) begin
                        void'(ras.pop_front());
                        m_err = 1;
                    end
                    ras.push_back(b.ras_link);
                end
            end
`endif
            m_pc = tgt - (tgt % STEP);
        end else if (b.en_f) begin
            m_pc = m_pc + STEP;
        end
    endtask

    task automatic check_model();
        chk("pc", b.pc, m_pc);
        chk("halted", 32'(b.halted), 32'(m_halt));
        chk("ras_empty", 32'(b.ras_empty), 32'(ras.size() == 0));
        chk("ras_full", 32'(b.ras_full), 32'(ras.size() == DEPTH));
        chk("ras_err", 32'(b.ras_err), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic clr();
        b.en_f = 0; b.ct_taken = 0; b.ct_pc = '0; b.ras_push = 0; b.ras_link = '0;
        b.ras_pop = 0; b.hlt = 0; b.start = 0;
        s.en_f = 0; s.ct_taken = 0; s.ct_pc = '0; s.ras_push = 0; s.ras_link = '0;
        s.ras_pop = 0; s.hlt = 0; s.start = 0;
    endtask

    initial begin
        clr();
        n_rst = 0;
        step(); step();
        chk("rst_pc", b.pc, 32'h0);
        chk("rst_halted", 32'(b.halted), 32'h0);
        chk("rst_empty", 32'(b.ras_empty), 32'h1);
        chk("rst_full", 32'(b.ras_full), 32'h0);
        chk("rst_err", 32'(b.ras_err), 32'h0);

        n_rst = 1; b.en_f = 1;
        step(); chk("inc4", b.pc, 32'h4);
        step(); chk("inc8", b.pc, 32'h8);
        step(); chk("inc12", b.pc, 32'hC);

        b.ct_taken = 1; b.ct_pc = 32'h102;
        step(); chk("redir_align", b.pc, 32'h100);

        b.ras_push = 1;
        for (int i = 1; i <= 5; i++) begin
            b.ras_link = 32'(i * 16);
            b.ct_pc    = 32'(32'h1000 + i * 16);
            step();
        end
`ifdef PC_RAS_EN
        chk("push_full", 32'(b.ras_full), 32'h1);
        chk("push_err", 32'(b.ras_err), 32'h1);
`endif
        b.ras_push = 0; b.ras_pop = 1; b.ct_pc = 32'h80;
        for (int i = 5; i >= 2; i--) begin
            step();
`ifdef PC_RAS_EN
            chk("pop_tgt", b.pc, 32'(i * 16));
`endif
        end
        chk("pop_empty", 32'(b.ras_empty), 32'h1);
        step(); chk("pop_underflow", b.pc, 32'h80);

        b.ras_pop = 0; b.ras_push = 1; b.ras_link = 32'h20; b.ct_pc = 32'h300;
        step();
        b.ras_pop = 1; b.ras_link = 32'h60; b.ct_pc = 32'h304;
        step();
`ifdef PC_RAS_EN
        chk("tail_tgt", b.pc, 32'h20);
        chk("tail_cnt", 32'(b.ras_empty), 32'h0);
`else
        chk("tail_tgt", b.pc, 32'h304);
`endif
        b.ras_push = 0; b.ct_pc = 32'h308;
        step();
`ifdef PC_RAS_EN
        chk("tail_next", b.pc, 32'h60);
`endif

        b.ras_pop = 0; b.ras_push = 1; b.ras_link = 32'h70; b.ct_pc = 32'h40;
        step(); chk("pre_hlt", b.pc, 32'h40);
        b.ras_push = 0; b.ct_taken = 0; b.hlt = 1;
        step();
        chk("hlt_pc", b.pc, 32'h0);
        chk("hlt_halted", 32'(b.halted), 32'h1);
        chk("hlt_empty", 32'(b.ras_empty), 32'h1);
        b.hlt = 0;
        step(); step();
        chk("halt_hold", b.pc, 32'h0);
        b.hlt = 1; b.start = 1;
        step(); chk("hlt_and_start", 32'(b.halted), 32'h1);
        b.hlt = 0; b.ct_taken = 1; b.ct_pc = 32'h500;
        step();
        chk("resume_halted", 32'(b.halted), 32'h0);
        chk("resume_pc", b.pc, 32'h0);
        b.start = 0; b.ct_taken = 0;
        step(); chk("resume_inc", b.pc, 32'h4);

        s.ct_taken = 1; s.ct_pc = 8'hFC;
        step(); chk("w8_set", 32'(s.pc), 32'hFC);
        s.ct_taken = 0; s.en_f = 1;
        step(); chk("w8_wrap", 32'(s.pc), 32'h0);
        s.en_f = 0;

        b.ct_taken = 1; b.ras_pop = 1; b.ct_pc = 32'h600;
        step();
        b.ras_pop = 0; b.ras_push = 1; b.ct_pc = 32'h700; n_rst = 0;
        step();
        chk("midrst_pc", b.pc, RST_PC);
        chk("midrst_err", 32'(b.ras_err), 32'h0);
        n_rst = 1;

        repeat (400) begin
            n_rst      = ($urandom_range(63) != 0);
            b.hlt      = ($urandom_range(15) == 0);
            b.start    = ($urandom_range(3) == 0);
            b.ct_taken = ($urandom_range(2) == 0);
            b.en_f     = ($urandom_range(3) != 0);
            b.ras_push = 1'($urandom_range(1));
            b.ras_pop  = 1'($urandom_range(1));
            b.ct_pc    = $urandom;
            b.ras_link = $urandom;
            if ($urandom_range(7) == 0) b.ct_pc = 32'hFFFFFFF0 | 32'($urandom_range(15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
